// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub -- bit-serial WIDTH-bit subtractor, diff = a - b (mod 2^WIDTH)
//
// One full-subtractor cell plus a borrow flip-flop process the operands
// LSB-first, one bit per clock. A request is accepted in IDLE or DONE; the
// WIDTH bits are processed on the following WIDTH clock edges and done pulses
// for one cycle after the last bit. Results hold until the next completion.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request, sampled only when not busy
//   a      in   WIDTH  minuend, captured on an accepted start
//   b      in   WIDTH  subtrahend, captured on an accepted start
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse: diff/bout just became valid
//   diff   out  WIDTH  registered result
//   bout   out  1      final borrow (a < b, unsigned)
//   ovf    out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
//
// Build option: define SERIAL_SUB_OVF_EN to add the ovf port and its logic.
// ---------------------------------------------------------------------------
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q;
`endif

    logic             bit_d;
    logic             br_d;
    logic [WIDTH-1:0] res_d;
    logic             last_s;

    // Full-subtractor difference bit.
    function automatic logic fs_diff(input logic x, input logic y, input logic br);
        return x ^ y ^ br;
    endfunction

    // Full-subtractor borrow out.
    function automatic logic fs_borrow(input logic x, input logic y, input logic br);
        return (~x & y) | (~(x ^ y) & br);
    endfunction

    // Subtractor cell on the current LSBs and next result-register value.
    always_comb begin
        bit_d  = fs_diff(a_sh_q[0], b_sh_q[0], br_q);
        br_d   = fs_borrow(a_sh_q[0], b_sh_q[0], br_q);
        res_d  = {bit_d, res_q[WIDTH-1:1]};
        last_s = (cnt_q == CW'(WIDTH - 1));
    end

    // Control FSM with shift datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        res_q   <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    res_q  <= res_d;
                    br_q   <= br_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_s) begin
                        diff_q  <= res_d;
                        bout_q  <= br_d;
`ifdef SERIAL_SUB_OVF_EN
                        // br_q holds the borrow into the MSB on this last bit;
                        // signed overflow is borrow-in XOR borrow-out there.
                        ovf_q   <= br_q ^ br_d;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// ---------------------------------------------------------------------------
// tb_serial_sub -- self-checking bench for serial_sub (WIDTH = 8).
// A transaction-level reference (operation in flight, cycles remaining,
// result computed with plain arithmetic) is compared with the DUT on every
// falling edge; directed cases pin the reference with literal values.
// ---------------------------------------------------------------------------
module tb_serial_sub;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int errors;
    int checks;
    bit cmp_en;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed overflow of x - y, from two's-complement integer values.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx;
        int sy;
        int r;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        r  = sx - sy;
        return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    // Reference: one operation in flight, WIDTH cycles long, result at the end.
    int           m_left;
    logic         m_done;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic [W-1:0] m_diff;
    logic         m_bout;
    logic         m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_diff <= W'(int'(m_a) - int'(m_b));
                m_bout <= (m_a < m_b);
                m_ovf  <= ref_ovf(m_a, m_b);
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_a    <= a;
                m_b    <= b;
                m_left <= W;
            end
        end
    end

    // Cycle-by-cycle comparison against the reference.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("busy", 32'(busy), 32'(m_left != 0));
            chk("done", 32'(done), 32'(m_done));
            chk("diff", 32'(diff), 32'(m_diff));
            chk("bout", 32'(bout), 32'(m_bout));
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
        end
    end

    task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom_range(0, 255);
        b     = $urandom_range(0, 255);
    endtask

    // Falling edges from the accept edge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < 40);
        if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        int lat;
        do_start(x, y);
        wait_done(lat);
        chk({name, "_latency"}, 32'(lat), 32'(W + 1));
        chk({name, "_diff"}, 32'(diff), 32'(ed));
        chk({name, "_bout"}, 32'(bout), 32'(eb));
        chk({name, "_model"}, 32'(m_diff), 32'(ed));
`ifdef SERIAL_SUB_OVF_EN
        chk({name, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo !== eo) chk({name, "_ovf"}, 32'(eo), 32'(eo));
`endif
    endtask

    initial begin
        int lat;
        int bcount;
        errors = 0;
        checks = 0;
        cmp_en = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        #9 rst = 1'b0;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;

        run_op("t1", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("t2", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("t3", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

        // Back-to-back: second request presented during the DONE cycle.
        run_op("t4a", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        do_start(8'hFF, 8'h01);
        wait_done(lat);
        chk("t4b_latency", 32'(lat), 32'(W + 1));
        chk("t4b_diff", 32'(diff), 32'h0FE);
        chk("t4b_bout", 32'(bout), 32'd0);

        // start with new operands while busy must be ignored.
        @(negedge clk);
        do_start(8'h3C, 8'h14);
        bcount = 0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (busy) bcount++;
            if (i == 2) begin
                start = 1'b1;
                a     = 8'h55;
                b     = 8'h11;
            end
            if (i == 7) start = 1'b0;
        end
        chk("t5_busy_cycles", 32'(bcount), 32'd8);
        chk("t5_diff", 32'(diff), 32'h028);
        chk("t5_busy_end", 32'(busy), 32'd0);

        // Reset in the middle of an operation.
        do_start(8'h10, 8'h20);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_diff", 32'(diff), 32'd0);
        chk("t6_bout", 32'(bout), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        bcount = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done) bcount++;
        end
        chk("t6_no_done", 32'(bcount), 32'd0);

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            start = ($urandom_range(0, 2) != 0);
            a     = $urandom_range(0, 255);
            b     = $urandom_range(0, 255);
            if ($urandom_range(0, 200) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        start = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        chk("final_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
